// File: rtl/sdram_read_master_if.sv
// Avalon-MM read bus plus the outgoing word stream of sdram_read_master.
// Modports: master = initiator/stream source, slave = SDRAM port/stream sink.
interface sdram_read_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_waitrequest;
    logic [DATA_W-1:0] m_readdata;
    logic              m_readdatavalid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output m_address, m_read,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        output out_data, out_valid,
        input  out_ready
    );

    modport slave (
        input  m_address, m_read,
        output m_waitrequest, m_readdata, m_readdatavalid,
        input  out_data, out_valid,
        output out_ready
    );
endinterface

// File: rtl/sdram_read_master.sv
// Pipelined Avalon-MM block reader with credit-limited issue into a FIFO.
// Ports: clk, reset_n, start/base_addr/length in, busy/done out, bus (master).
module sdram_read_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    sdram_read_master_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state_q, state_d;
    logic               done_q, done_d;
    logic               stall_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   issue_left_q;
    logic [LEN_W-1:0]   deliver_left_q;
    logic [CNT_W-1:0]   pending_q;
    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];

    logic               credit_ok;
    logic               rd_req;
    logic               accept;
    logic               push;
    logic               pop;
    logic               valid;
    logic               load;

    // pending + count bounds every word that may still land in the FIFO
    assign credit_ok = ({1'b0, pending_q} + {1'b0, count_q})
                       < (CNT_W + 1)'(FIFO_DEPTH);
    // a stalled request is held regardless of the current credit
    assign rd_req = (state_q == ISSUE) && (stall_q || credit_ok);
    assign accept = rd_req && !bus.m_waitrequest;
    assign push   = bus.m_readdatavalid && (pending_q != '0);
    assign valid  = (count_q != '0);
    assign pop    = valid && bus.out_ready;
    assign load   = (state_q == IDLE) && start && (length != '0);

    assign bus.m_read    = rd_req;
    assign bus.m_address = addr_q;
    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? mem[rd_ptr_q] : '0;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (1'b1)
            state_q == IDLE: begin
                if (start) begin
                    if (length != '0) state_d = ISSUE;
                    else              done_d  = 1'b1;
                end
            end
            state_q == ISSUE: begin
                if (accept && issue_left_q == LEN_W'(1))
                    state_d = DRAIN;
            end
            state_q == DRAIN: begin
                if (pop && deliver_left_q == LEN_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            done_q         <= 1'b0;
            stall_q        <= 1'b0;
            addr_q         <= '0;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
            pending_q      <= '0;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            stall_q <= rd_req && bus.m_waitrequest;
            if (load) begin
                addr_q         <= base_addr;
                issue_left_q   <= length;
                deliver_left_q <= length;
            end else begin
                if (accept) begin
                    addr_q       <= addr_q + STEP;
                    issue_left_q <= issue_left_q - LEN_W'(1);
                end
                if (pop)
                    deliver_left_q <= deliver_left_q - LEN_W'(1);
            end
            pending_q <= pending_q + CNT_W'(accept) - CNT_W'(push);
            count_q   <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // storage needs no reset: out_data is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.m_readdata;
    end
endmodule
